// File: rtl/i2s_transceiver_if.sv
// -----------------------------------------------------------------------------
// i2s_transceiver_if
// Sample-stream bundle between the sample-processing logic and the I2S
// transceiver.
//   tx_left/tx_right/tx_valid : transmit sample pair offered by the producer
//   tx_ready                  : transceiver holding buffer is empty
//   tx_underrun               : one-cycle pulse, a frame started with no pair
//   rx_left/rx_right/rx_valid : received sample pair, one-cycle valid pulse
// Modports: master = sample-processing side, slave = transceiver side.
// -----------------------------------------------------------------------------
interface i2s_transceiver_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] tx_left;
    logic [DATA_WIDTH-1:0] tx_right;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [DATA_WIDTH-1:0] rx_left;
    logic [DATA_WIDTH-1:0] rx_right;
    logic                  rx_valid;

    modport master (
        output tx_left, tx_right, tx_valid,
        input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );

    modport slave (
        input  tx_left, tx_right, tx_valid,
        output tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );
endinterface

// File: rtl/i2s_transceiver.sv
// -----------------------------------------------------------------------------
// i2s_transceiver
// Stereo I2S master for the WM8731 codec datapath. Derives bclk/lrclk from clk,
// serialises a one-entry buffered TX sample pair onto i2s_dacdat and
// deserialises i2s_adcdat into an RX sample pair presented once per frame.
//
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   bus (slave)   : TX valid/ready stream, underrun pulse, RX samples + valid
//   i2s_bclk      : bit clock, clk / (2*BCLK_HALF)
//   i2s_lrclk     : word select, 0 = left slot, 1 = right slot
//   i2s_dacdat    : serial data to the codec DAC, changes on bclk falling edge
//   i2s_adcdat    : serial data from the codec ADC, asynchronous to clk
//
// Build option:
//   I2S_ONE_BIT_DELAY_EN defined   -> Philips I2S, MSB one bclk after lrclk edge
//   I2S_ONE_BIT_DELAY_EN undefined -> left-justified, MSB on the lrclk edge
// -----------------------------------------------------------------------------
module i2s_transceiver #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_HALF  = 12
) (
    input  logic             clk,
    input  logic             rst,
    i2s_transceiver_if.slave bus,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_dacdat,
    input  logic             i2s_adcdat
);

    localparam int HW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [HW-1:0] HCNT_LAST = HW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN  = BW'(SLOT_BITS);

    localparam logic [DATA_WIDTH-1:0] ZERO_SAMPLE = {DATA_WIDTH{1'b0}};

    // Position of a bit counter value inside its channel slot.
    function automatic logic [BW-1:0] slot_pos(input logic [BW-1:0] b);
        logic [BW-1:0] p;
        if (b >= SLOT_LEN) begin
            p = b - SLOT_LEN;
        end else begin
            p = b;
        end
        return p;
    endfunction

    // True when a slot position carries a data bit for the selected format.
    function automatic logic is_data_pos(input logic [BW-1:0] p);
        logic r;
`ifdef I2S_ONE_BIT_DELAY_EN
        r = (p != {BW{1'b0}}) && (p <= BW'(DATA_WIDTH));
`else
        r = (p < BW'(DATA_WIDTH));
`endif
        return r;
    endfunction

    // Clock generation state
    logic [HW-1:0]         hcnt_q,     hcnt_d;
    logic                  bclk_q,     bclk_d;
    logic [BW-1:0]         bcnt_q,     bcnt_d;
    logic                  lrclk_q,    lrclk_d;
    // TX state
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_l_q,    buf_l_d;
    logic [DATA_WIDTH-1:0] buf_r_q,    buf_r_d;
    logic [DATA_WIDTH-1:0] tx_sh_l_q,  tx_sh_l_d;
    logic [DATA_WIDTH-1:0] tx_sh_r_q,  tx_sh_r_d;
    logic                  dacdat_q,   dacdat_d;
    logic                  underrun_q, underrun_d;
    // RX state
    logic                  adc_meta_q, adc_meta_d;
    logic                  adc_sync_q, adc_sync_d;
    logic [DATA_WIDTH-1:0] rx_sh_l_q,  rx_sh_l_d;
    logic [DATA_WIDTH-1:0] rx_sh_r_q,  rx_sh_r_d;
    logic [DATA_WIDTH-1:0] rx_left_q,  rx_left_d;
    logic [DATA_WIDTH-1:0] rx_right_q, rx_right_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  started_q,  started_d;

    // Event strobes
    logic                  hwrap_s;
    logic                  fall_s;
    logic                  rise_s;
    logic                  frame_start_s;
    logic [BW-1:0]         bcnt_next_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] tx_cur_l_s;
    logic [DATA_WIDTH-1:0] tx_cur_r_s;

    // Decode bclk edge events and the bit counter successor.
    always_comb begin
        hwrap_s       = (hcnt_q == HCNT_LAST);
        fall_s        = hwrap_s && bclk_q;
        rise_s        = hwrap_s && !bclk_q;
        frame_start_s = fall_s && (bcnt_q == BCNT_LAST);
        if (bcnt_q == BCNT_LAST) begin
            bcnt_next_s = {BW{1'b0}};
        end else begin
            bcnt_next_s = bcnt_q + BW'(1);
        end
        accept_s = bus.tx_valid && !buf_full_q;
    end

    // Half-period counter, bclk toggle, bit counter and word select.
    always_comb begin
        hcnt_d  = hcnt_q;
        bclk_d  = bclk_q;
        bcnt_d  = bcnt_q;
        lrclk_d = lrclk_q;
        if (hwrap_s) begin
            hcnt_d = {HW{1'b0}};
            bclk_d = !bclk_q;
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end
        if (fall_s) begin
            bcnt_d  = bcnt_next_s;
            lrclk_d = (bcnt_next_s >= SLOT_LEN);
        end else begin
            bcnt_d  = bcnt_q;
            lrclk_d = lrclk_q;
        end
    end

    // TX holding buffer, frame load, shift-out and underrun detection.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        tx_sh_l_d  = tx_sh_l_q;
        tx_sh_r_d  = tx_sh_r_q;
        dacdat_d   = dacdat_q;
        underrun_d = frame_start_s && !buf_full_q;

        // On a frame start the shifters are replaced by the buffer (or zeros)
        // before the first bit of the new frame is picked.
        if (frame_start_s) begin
            tx_cur_l_s = buf_full_q ? buf_l_q : ZERO_SAMPLE;
            tx_cur_r_s = buf_full_q ? buf_r_q : ZERO_SAMPLE;
        end else begin
            tx_cur_l_s = tx_sh_l_q;
            tx_cur_r_s = tx_sh_r_q;
        end

        if (frame_start_s && buf_full_q) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
        // An accept coinciding with an empty-buffer frame start is kept for
        // the following frame; the current frame still underruns.
        if (accept_s) begin
            buf_full_d = 1'b1;
            buf_l_d    = bus.tx_left;
            buf_r_d    = bus.tx_right;
        end else begin
            buf_l_d    = buf_l_q;
            buf_r_d    = buf_r_q;
        end

        if (fall_s) begin
            tx_sh_l_d = tx_cur_l_s;
            tx_sh_r_d = tx_cur_r_s;
            dacdat_d  = 1'b0;
            if (is_data_pos(slot_pos(bcnt_next_s))) begin
                if (bcnt_next_s >= SLOT_LEN) begin
                    dacdat_d  = tx_cur_r_s[DATA_WIDTH-1];
                    tx_sh_r_d = {tx_cur_r_s[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    dacdat_d  = tx_cur_l_s[DATA_WIDTH-1];
                    tx_sh_l_d = {tx_cur_l_s[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                dacdat_d = 1'b0;
            end
        end else begin
            dacdat_d = dacdat_q;
        end
    end

    // ADC synchroniser, RX shift-in and per-frame output update.
    always_comb begin
        adc_meta_d = i2s_adcdat;
        adc_sync_d = adc_meta_q;
        rx_sh_l_d  = rx_sh_l_q;
        rx_sh_r_d  = rx_sh_r_q;
        rx_left_d  = rx_left_q;
        rx_right_d = rx_right_q;
        rx_valid_d = frame_start_s && started_q;
        started_d  = started_q;

        // lrclk_q still describes bcnt_q on a rise event, so it selects the
        // channel being received.
        if (rise_s && is_data_pos(slot_pos(bcnt_q))) begin
            if (lrclk_q) begin
                rx_sh_r_d = {rx_sh_r_q[DATA_WIDTH-2:0], adc_sync_q};
            end else begin
                rx_sh_l_d = {rx_sh_l_q[DATA_WIDTH-2:0], adc_sync_q};
            end
        end else begin
            rx_sh_l_d = rx_sh_l_q;
            rx_sh_r_d = rx_sh_r_q;
        end

        // The first frame start after reset has no complete frame behind it.
        if (frame_start_s) begin
            started_d = 1'b1;
            if (started_q) begin
                rx_left_d  = rx_sh_l_q;
                rx_right_d = rx_sh_r_q;
            end else begin
                rx_left_d  = rx_left_q;
                rx_right_d = rx_right_q;
            end
        end else begin
            started_d = started_q;
        end
    end

    // State register for every flop in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q     <= {HW{1'b0}};
            bclk_q     <= 1'b0;
            bcnt_q     <= BCNT_LAST;
            lrclk_q    <= 1'b0;
            buf_full_q <= 1'b0;
            buf_l_q    <= ZERO_SAMPLE;
            buf_r_q    <= ZERO_SAMPLE;
            tx_sh_l_q  <= ZERO_SAMPLE;
            tx_sh_r_q  <= ZERO_SAMPLE;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
            adc_meta_q <= 1'b0;
            adc_sync_q <= 1'b0;
            rx_sh_l_q  <= ZERO_SAMPLE;
            rx_sh_r_q  <= ZERO_SAMPLE;
            rx_left_q  <= ZERO_SAMPLE;
            rx_right_q <= ZERO_SAMPLE;
            rx_valid_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            bclk_q     <= bclk_d;
            bcnt_q     <= bcnt_d;
            lrclk_q    <= lrclk_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            tx_sh_l_q  <= tx_sh_l_d;
            tx_sh_r_q  <= tx_sh_r_d;
            dacdat_q   <= dacdat_d;
            underrun_q <= underrun_d;
            adc_meta_q <= adc_meta_d;
            adc_sync_q <= adc_sync_d;
            rx_sh_l_q  <= rx_sh_l_d;
            rx_sh_r_q  <= rx_sh_r_d;
            rx_left_q  <= rx_left_d;
            rx_right_q <= rx_right_d;
            rx_valid_q <= rx_valid_d;
            started_q  <= started_d;
        end
    end

    assign i2s_bclk        = bclk_q;
    assign i2s_lrclk       = lrclk_q;
    assign i2s_dacdat      = dacdat_q;
    assign bus.tx_ready    = !buf_full_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.rx_left     = rx_left_q;
    assign bus.rx_right    = rx_right_q;
    assign bus.rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_i2s_transceiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_transceiver
// Scoreboard bench for i2s_transceiver. The stimulus thread pushes expected TX
// frames; a codec model drives i2s_adcdat and pushes expected RX pairs; a
// monitor decodes the I2S pins and pops/compares at every frame start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_transceiver;
    localparam int DW    = 24;
    localparam int SB    = 32;
    localparam int BH    = 12;
    localparam int FRAME = 2 * SB * 2 * BH;
`ifdef I2S_ONE_BIT_DELAY_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          und;
    } tx_exp_t;
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk, lrclk, dacdat;
    logic adcdat = 1'b0;

    i2s_transceiver_if #(.DATA_WIDTH(DW)) bus ();

    i2s_transceiver #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCLK_HALF(BH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .i2s_bclk   (bclk),
        .i2s_lrclk  (lrclk),
        .i2s_dacdat (dacdat),
        .i2s_adcdat (adcdat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    // Monitor state shared with the stimulus thread (read only there).
    int m_bcnt;
    int fs_cnt;
    int spurious_rx  = 0;
    int spurious_und = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},     bclk, 0);
        check({tag, "_lrclk"},    lrclk, 0);
        check({tag, "_dacdat"},   dacdat, 0);
        check({tag, "_tx_ready"}, bus.tx_ready, 1);
        check({tag, "_underrun"}, bus.tx_underrun, 0);
        check({tag, "_rx_left"},  bus.rx_left, 0);
        check({tag, "_rx_right"}, bus.rx_right, 0);
        check({tag, "_rx_valid"}, bus.rx_valid, 0);
    endtask

    task automatic push_tx(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic und);
        tx_exp_t e;
        e.l = l; e.r = r; e.und = und;
        tx_q.push_back(e);
    endtask

    task automatic wait_fs(input int n);
        int k = 0;
        while (fs_cnt < n && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("wait_frame_start", (fs_cnt >= n), 1);
    endtask

    // Cycle counter: after active edge k following reset release, cyc == k+1.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Codec ADC model: new bit on each bclk fall, pattern alternates per frame.
    logic [DW-1:0] pat_l [2];
    logic [DW-1:0] pat_r [2];
    initial begin
        pat_l[0] = 24'h800001; pat_r[0] = 24'h7FFFFF;
        pat_l[1] = 24'h123456; pat_r[1] = 24'hFEDCBA;
    end
    int   c_bcnt;
    int   c_frame;
    logic c_prev;
    logic [DW-1:0] c_l, c_r;
    always @(negedge clk) begin
        if (rst) begin
            c_bcnt = 2 * SB - 1; c_frame = 0; c_prev = 1'b0;
            adcdat = 1'b0;
            rx_q.delete();
        end else begin
            if (c_prev && !bclk) begin
                int p;
                rx_exp_t e;
                c_bcnt = (c_bcnt + 1) % (2 * SB);
                if (c_bcnt == 0) begin
                    c_l = pat_l[c_frame % 2];
                    c_r = pat_r[c_frame % 2];
                    e.l = c_l; e.r = c_r;
                    rx_q.push_back(e);
                    c_frame++;
                end
                p = c_bcnt % SB;
                if (p >= OFS && p < OFS + DW)
                    adcdat = (c_bcnt >= SB) ? c_r[DW-1-(p-OFS)] : c_l[DW-1-(p-OFS)];
                else
                    adcdat = 1'b0;
            end
            c_prev = bclk;
        end
    end

    // Monitor: decode i2s_dacdat, timing, and compare against the queues.
    logic m_prev_bclk, m_prev_lr, cur_und;
    logic [DW-1:0] dec_l, dec_r;
    int pad, last_lr_rise;
    always @(negedge clk) begin
        if (rst) begin
            m_bcnt = 2 * SB - 1; fs_cnt = 0; m_prev_bclk = 1'b0; m_prev_lr = 1'b0;
            dec_l = '0; dec_r = '0; pad = 0; cur_und = 1'b0; last_lr_rise = -1;
        end else begin
            logic fs;
            fs = 1'b0;
            if (m_prev_bclk && !bclk) begin
                m_bcnt = (m_bcnt + 1) % (2 * SB);
                fs = (m_bcnt == 0);
            end
            if (!m_prev_bclk && bclk) begin
                int p;
                p = m_bcnt % SB;
                if (p >= OFS && p < OFS + DW) begin
                    if (m_bcnt >= SB) dec_r = {dec_r[DW-2:0], dacdat};
                    else              dec_l = {dec_l[DW-2:0], dacdat};
                end else if (dacdat) begin
                    pad++;
                end
            end
            if (fs) begin
                if (fs_cnt == 0) begin
                    check("first_fall_cycle", cyc - 1, 23);
                    check("no_rx_valid_first_frame", bus.rx_valid, 0);
                end else begin
                    if (tx_q.size() > 0) begin
                        tx_exp_t e;
                        e = tx_q.pop_front();
                        check("tx_left",     dec_l, e.l);
                        check("tx_right",    dec_r, e.r);
                        check("tx_underrun", cur_und, e.und);
                        check("tx_padding",  pad, 0);
                    end
                    check("rx_valid_at_frame_start", bus.rx_valid, 1);
                    if (bus.rx_valid && rx_q.size() > 0) begin
                        rx_exp_t r;
                        r = rx_q.pop_front();
                        check("rx_left",  bus.rx_left, r.l);
                        check("rx_right", bus.rx_right, r.r);
                    end
                end
                cur_und = bus.tx_underrun;
                fs_cnt++;
                dec_l = '0; dec_r = '0; pad = 0;
            end else begin
                if (bus.rx_valid)    spurious_rx++;
                if (bus.tx_underrun) spurious_und++;
            end
            if (!m_prev_lr && lrclk) begin
                if (last_lr_rise >= 0) check("lrclk_period", cyc - last_lr_rise, FRAME);
                last_lr_rise = cyc;
            end
            m_prev_bclk = bclk;
            m_prev_lr   = lrclk;
        end
    end

    // Directed stimulus.
    logic [DW-1:0] bp_l [4];
    logic [DW-1:0] bp_r [4];
    int acc_cyc [4];
    initial begin
        bp_l[0] = 24'h111111; bp_r[0] = 24'hEEEEEE;
        bp_l[1] = 24'h000001; bp_r[1] = 24'h800000;
        bp_l[2] = 24'hFFFFFF; bp_r[2] = 24'h000000;
        bp_l[3] = 24'h5A5A5A; bp_r[3] = 24'hC3C3C3;
        bus.tx_left = '0; bus.tx_right = '0; bus.tx_valid = 1'b0;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        // TX pattern before the first frame, then two underrun frames.
        rst = 1'b0;
        bus.tx_left = 24'hA5A5A5; bus.tx_right = 24'h3C3C3C; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        push_tx(24'hA5A5A5, 24'h3C3C3C, 1'b0);
        push_tx('0, '0, 1'b1);
        push_tx('0, '0, 1'b1);
        @(negedge clk);
        check("tx_ready_after_accept", bus.tx_ready, 0);

        // Back-pressure: valid held high across four pairs.
        wait_fs(3);
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int k;
            bus.tx_left = bp_l[i]; bus.tx_right = bp_r[i];
            k = 0;
            while (!bus.tx_ready && k < 2 * FRAME) begin
                @(negedge clk);
                k++;
            end
            check("accept_wait", bus.tx_ready, 1);
            @(posedge clk); #1;
            acc_cyc[i] = cyc;
            push_tx(bp_l[i], bp_r[i], 1'b0);
            @(negedge clk);
            check("tx_ready_backpressure", bus.tx_ready, 0);
        end
        bus.tx_valid = 1'b0;
        check("consume_rate_1", acc_cyc[2] - acc_cyc[1], FRAME);
        check("consume_rate_2", acc_cyc[3] - acc_cyc[2], FRAME);

        // Reset in the middle of the right slot.
        wait_fs(9);
        begin
            int k = 0;
            while (m_bcnt != 40 && k < 2 * FRAME) begin
                @(negedge clk);
                k++;
            end
            check("reach_bcnt_40", m_bcnt, 40);
        end
        check("rx_left_before_reset_nonzero", (bus.rx_left != '0), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.tx_left = 24'h0F0F0F; bus.tx_right = 24'hF0F0F0; bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        push_tx(24'h0F0F0F, 24'hF0F0F0, 1'b0);
        wait_fs(3);

        check("tx_queue_drained", tx_q.size(), 0);
        check("spurious_rx_valid", spurious_rx, 0);
        check("spurious_underrun", spurious_und, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2s_transceiver.md
# i2s_transceiver

Stereo I2S master transceiver for the WM8731 codec datapath. It generates `i2s_bclk` and `i2s_lrclk` from the 73.728 MHz system clock: fs = 48 kHz and 64 bclk per frame by default. Transmit side: serialises 24-bit left/right samples from a valid/ready stream onto `i2s_dacdat`. Receive side: deserialises `i2s_adcdat` into 24-bit left/right samples, presented as a one-cycle valid pulse. It sits between the sample-processing logic and the codec pins, alongside the mclk generator.

## Interface
- `DATA_WIDTH`, 24: bits per channel sample.
- `SLOT_BITS`, 32: bclk periods per channel slot. Must be ≥ DATA_WIDTH+1.
- `BCLK_HALF`, 12: clk cycles per bclk half-period. bclk = clk/(2·BCLK_HALF).
- `clk` in 1: system clock, 73.728 MHz.
- `rst` in 1: reset. Synchronous, active-high; clock `clk`.
- `tx_left` in DATA_WIDTH: left sample to transmit, two's complement.
- `tx_right` in DATA_WIDTH: right sample to transmit.
- `tx_valid` in 1: tx sample pair valid.
- `tx_ready` out 1: one-entry holding buffer is empty.
- `tx_underrun` out 1: one-cycle pulse when a frame starts with the buffer empty.
- `rx_left` out DATA_WIDTH: last received left sample.
- `rx_right` out DATA_WIDTH: last received right sample.
- `rx_valid` out 1: one-cycle pulse when `rx_left`/`rx_right` update. No backpressure.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrclk` out 1: word select. 0 = left, 1 = right.
- `i2s_dacdat` out 1: serial data to the codec DAC.
- `i2s_adcdat` in 1: serial data from the codec ADC. Asynchronous to clk.

## Operation
- **Half-period counter**
  - `hcnt` counts 0..BCLK_HALF-1.
  - `i2s_bclk` toggles on the cycle `hcnt`==BCLK_HALF-1.
  - A toggle 1→0 is a *fall event*; a toggle 0→1 is a *rise event*.
- **Bit counter**
  - `bcnt` counts 0..2·SLOT_BITS-1 and advances on each fall event, wrapping to 0.
  - On the same fall event: `i2s_lrclk` <= (new `bcnt` ≥ SLOT_BITS).
  - A wrap to 0 is a *frame start*.
- **Slot mapping**
  - Slot position p = `bcnt` mod SLOT_BITS.
  - Data bit positions are p = 1..DATA_WIDTH when `I2S_ONE_BIT_DELAY_EN` is defined, p = 0..DATA_WIDTH-1 otherwise. Data is MSB first.
  - All other positions transmit 0 and are ignored on receive.
- **TX holding buffer**
  - `tx_ready` = !buf_full.
  - When `tx_valid` && `tx_ready`: capture both samples and set buf_full.
  - At frame start with buf_full: load the shift registers from the buffer and clear buf_full.
  - At frame start with the buffer empty: load zeros and pulse `tx_underrun`.
  - Same-cycle frame start and accept with the buffer empty: the frame underruns, and the accepted pair is used at the next frame start.
- **TX shift**
  - `i2s_dacdat` is updated only on fall events, to the bit for the new `bcnt`.
- **RX path**
  - `i2s_adcdat` passes through a 2-flop synchroniser.
  - The synchronised value is sampled on rise events at data positions and shifted in MSB first into the channel register selected by `i2s_lrclk`.
- **RX output**
  - At each frame start except the first after reset: `rx_left`/`rx_right` <= assembled values and `rx_valid` pulses for 1 cycle.

## Timing
- **Reset values**
  - `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_dacdat`=0.
  - `tx_ready`=1, `tx_underrun`=0.
  - `rx_left`=`rx_right`=0, `rx_valid`=0.
  - `hcnt`=0; `bcnt`=2·SLOT_BITS-1, so the first fall event is a frame start.
- **Clock edges after reset release**
  - First rise event at cycle BCLK_HALF-1.
  - First fall event (the first frame start) at cycle 2·BCLK_HALF-1.
- **Periods (defaults)**
  - Frame = 2·SLOT_BITS·2·BCLK_HALF = 1536 clk.
  - bclk period = 24 clk.
- **TX latency**
  - An accepted pair appears on `i2s_dacdat` at the next frame start.
  - Left MSB is at fall event 0 in left-justified mode, or fall event 1 with the one-bit delay.
- **RX latency:** a sample is visible on `rx_left`/`rx_right` at the frame start following its frame, concurrent with `rx_valid`.
- **Reset mid-frame:** the counters, buffer and shift registers are discarded and all outputs return to their reset values on the next clk edge.

## Configuration
- **`I2S_ONE_BIT_DELAY_EN`**
  - Defined: Philips I2S format; MSB one bclk after the `i2s_lrclk` edge, matching the WM8731 I2S mode.
  - Undefined: left-justified format; MSB coincides with the `i2s_lrclk` edge.

## Test plan
- **Reset:** hold `rst` 5 cycles → all outputs at reset values, then the first fall event at cycle 23 and `i2s_lrclk` period 1536 clk.
- **TX pattern:** send left=0xA5A5A5, right=0x3C3C3C before the first frame → `i2s_dacdat` decoded by the bench model equals those values in the selected format, with padding bits 0.
- **Underrun:** no `tx_valid` for 2 frames → `tx_underrun` pulses once per frame start and `i2s_dacdat` stays 0.
- **Back-pressure:** hold `tx_valid` high continuously → `tx_ready` deasserts after the first accept, one pair is consumed per 1536 clk, and no underrun occurs.
- **RX loopback:** `i2s_adcdat` driven by the codec model with left=0x800001, right=0x7FFFFF → `rx_valid` pulses once per frame with matching values, and no pulse at the first frame start.
- **Reset mid-frame:** assert `rst` at `bcnt`=40 → outputs reset, no spurious `rx_valid`, and the next frame starts 23 cycles after release.
